// File: rtl/filtro_biquad_tdm_pkg.sv
// -----------------------------------------------------------------------------
// filtro_biquad_tdm_pkg
// Shared definitions for the time-multiplexed biquad filter bank:
//   - coefficient slot indices inside each band's 5-word coefficient group
//   - FSM state encoding
//   - two's-complement saturation limits for an arbitrary width
// -----------------------------------------------------------------------------
package filtro_biquad_tdm_pkg;

  // Slot order inside a band. This is also the order in which the products
  // are evaluated.
  localparam logic [2:0] IDX_A1 = 3'd0;
  localparam logic [2:0] IDX_A2 = 3'd1;
  localparam logic [2:0] IDX_B0 = 3'd2;
  localparam logic [2:0] IDX_B1 = 3'd3;
  localparam logic [2:0] IDX_B2 = 3'd4;

  typedef enum logic {
    REPOSO  = 1'b0,
    CALCULO = 1'b1
  } estado_t;

  // Largest value representable in an 'ancho'-bit two's-complement word.
  function automatic logic signed [63:0] lim_max(input int ancho);
    return (64'sd1 <<< (ancho - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in an 'ancho'-bit two's-complement word.
  function automatic logic signed [63:0] lim_min(input int ancho);
    return -(64'sd1 <<< (ancho - 1));
  endfunction

endpackage

// File: rtl/filtro_biquad_tdm_mult_sat.sv
// -----------------------------------------------------------------------------
// filtro_biquad_tdm_mult_sat
// The single shared multiplier of the filter bank. Forms the full signed
// product, rescales it by FRACCION bits with an arithmetic shift (rounding
// toward minus infinity), and clamps the result to ANCHO_SAL bits.
//   op_a, op_b : signed ANCHO-bit operands (coefficient, state word)
//   prod       : signed ANCHO_SAL-bit rescaled, clamped product
// -----------------------------------------------------------------------------
module filtro_biquad_tdm_mult_sat
  import filtro_biquad_tdm_pkg::*;
#(
  parameter int ANCHO     = 23,
  parameter int FRACCION  = 14,
  parameter int ANCHO_SAL = 24
) (
  input  logic signed [ANCHO-1:0]     op_a,
  input  logic signed [ANCHO-1:0]     op_b,
  output logic signed [ANCHO_SAL-1:0] prod
);

  localparam int PW = 2 * ANCHO;
  localparam logic signed [PW-1:0] P_MAX = PW'(lim_max(ANCHO_SAL));
  localparam logic signed [PW-1:0] P_MIN = PW'(lim_min(ANCHO_SAL));

  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_esc;

  always_comb begin
    prod_full = op_a * op_b;
    prod_esc  = prod_full >>> FRACCION;
    // Clamping to one bit wider than a sample keeps the accumulator sum of
    // one sample plus two products inside ANCHO+3 bits.
    if (prod_esc > P_MAX) begin
      prod = ANCHO_SAL'(P_MAX);
    end else if (prod_esc < P_MIN) begin
      prod = ANCHO_SAL'(P_MIN);
    end else begin
      prod = prod_esc[ANCHO_SAL-1:0];
    end
  end

endmodule

// File: rtl/filtro_biquad_tdm.sv
// -----------------------------------------------------------------------------
// filtro_biquad_tdm
// Bank of N_BANDAS direct-form-II biquads, all fed by the same input sample
// and evaluated one after another through one shared multiplier. Each band
// takes five cycles (a1*w1, a2*w2, b0*w, b1*w1, b2*w2), so one sample
// occupies the datapath for 5*N_BANDAS cycles.
//   clk, reset : clock, synchronous active-high reset
//   en         : sample strobe, func_ent captured when accepted
//   func_ent   : signed input sample
//   coef_we    : coefficient write strobe (honoured only when idle, en low)
//   coef_dir   : coefficient address band*5 + slot (a1,a2,b0,b1,b2)
//   coef_dat   : signed coefficient; a1/a2 stored already negated
//   limpia     : clear all band delay lines (honoured only when idle)
//   sal_banda  : output of band sal_idx, held between strobes
//   sal_idx    : band index of sal_banda
//   sal_valid  : one-cycle strobe marking a new band output
//   busy       : high while a sample is being processed
//   perdida    : sticky flag, a strobe arrived while busy
// -----------------------------------------------------------------------------
module filtro_biquad_tdm
  import filtro_biquad_tdm_pkg::*;
#(
  parameter int ANCHO    = 23,
  parameter int MAGNITUD = 8,
  parameter int FRACCION = 14,
  parameter int N_BANDAS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic signed [ANCHO-1:0]           func_ent,
  input  logic                              coef_we,
  input  logic [$clog2(5*N_BANDAS)-1:0]     coef_dir,
  input  logic signed [ANCHO-1:0]           coef_dat,
  input  logic                              limpia,
  output logic signed [ANCHO-1:0]           sal_banda,
  output logic [$clog2(N_BANDAS)-1:0]       sal_idx,
  output logic                              sal_valid,
  output logic                              busy,
  output logic                              perdida
);

  localparam int NC = 5 * N_BANDAS;
  localparam int DW = $clog2(NC);
  localparam int BW = $clog2(N_BANDAS);
  localparam int AW = ANCHO + 3;
  localparam int PW = ANCHO + 1;

  localparam logic signed [AW-1:0]    ACC_MAX = AW'(lim_max(ANCHO));
  localparam logic signed [AW-1:0]    ACC_MIN = AW'(lim_min(ANCHO));
  localparam logic signed [ANCHO-1:0] UNO     = ANCHO'(1 << FRACCION);

  if (1 + MAGNITUD + FRACCION != ANCHO) begin : g_formato_invalido
    $error("ANCHO must equal 1 + MAGNITUD + FRACCION");
  end

  function automatic logic signed [ANCHO-1:0] sat(input logic signed [AW-1:0] v);
    if (v > ACC_MAX) return ANCHO'(ACC_MAX);
    if (v < ACC_MIN) return ANCHO'(ACC_MIN);
    return v[ANCHO-1:0];
  endfunction

  estado_t                  estado_q, estado_d;
  logic [BW-1:0]            banda_q, banda_d;
  logic [2:0]               idx_q, idx_d;
  logic                     perdida_q, perdida_d;
  logic signed [ANCHO-1:0]  sal_banda_q, sal_banda_d;
  logic [BW-1:0]            sal_idx_q, sal_idx_d;
  logic signed [ANCHO-1:0]  x_q, x_d;
  logic signed [ANCHO-1:0]  w_q, w_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [ANCHO-1:0]  w1_q [N_BANDAS];
  logic signed [ANCHO-1:0]  w1_d [N_BANDAS];
  logic signed [ANCHO-1:0]  w2_q [N_BANDAS];
  logic signed [ANCHO-1:0]  w2_d [N_BANDAS];
  logic signed [ANCHO-1:0]  coef_q [NC];
  logic signed [ANCHO-1:0]  coef_d [NC];

  logic [DW-1:0]            dir_sel;
  logic signed [ANCHO-1:0]  coef_sel;
  logic signed [ANCHO-1:0]  dato_sel;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     suma;

  // Operand selection for the product of the current (band, slot).
  always_comb begin
    dir_sel  = DW'(int'(banda_q) * 5 + int'(idx_q));
    coef_sel = coef_q[dir_sel];
    case (idx_q)
      IDX_A1, IDX_B1: dato_sel = w1_q[banda_q];
      IDX_A2, IDX_B2: dato_sel = w2_q[banda_q];
      default:        dato_sel = w_q;
    endcase
  end

  filtro_biquad_tdm_mult_sat #(
    .ANCHO     (ANCHO),
    .FRACCION  (FRACCION),
    .ANCHO_SAL (PW)
  ) u_mult_sat (
    .op_a (coef_sel),
    .op_b (dato_sel),
    .prod (prod)
  );

  assign suma = acc_q + AW'(prod);

  always_comb begin
    estado_d    = estado_q;
    banda_d     = banda_q;
    idx_d       = idx_q;
    perdida_d   = perdida_q;
    sal_banda_d = sal_banda_q;
    sal_idx_d   = sal_idx_q;
    x_d         = x_q;
    w_d         = w_q;
    acc_d       = acc_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    coef_d      = coef_q;
    sal_valid   = 1'b0;
    sal_banda   = sal_banda_q;
    sal_idx     = sal_idx_q;
    busy        = (estado_q == CALCULO);

    case (estado_q)
      REPOSO: begin
        // The extra bit keeps the range check correct when 5*N_BANDAS is a
        // power of two.
        if (coef_we && !en && ({1'b0, coef_dir} < (DW + 1)'(NC))) begin
          coef_d[coef_dir] = coef_dat;
        end
        if (limpia) begin
          for (int b = 0; b < N_BANDAS; b++) begin
            w1_d[b] = '0;
            w2_d[b] = '0;
          end
        end
        if (en) begin
          estado_d = CALCULO;
          x_d      = func_ent;
          banda_d  = '0;
          idx_d    = IDX_A1;
        end
      end

      default: begin
        if (en) perdida_d = 1'b1;

        case (idx_q)
          IDX_A1: acc_d = AW'(x_q) + AW'(prod);
          IDX_A2: w_d   = sat(suma);
          IDX_B0: acc_d = AW'(prod);
          IDX_B1: acc_d = suma;
          default: begin
            // Last product of the band: emit y and shift the delay line.
            sal_valid         = 1'b1;
            sal_banda         = sat(suma);
            sal_idx           = banda_q;
            sal_banda_d       = sal_banda;
            sal_idx_d         = banda_q;
            w2_d[banda_q]     = w1_q[banda_q];
            w1_d[banda_q]     = w_q;
          end
        endcase

        if (idx_q == IDX_B2) begin
          idx_d = IDX_A1;
          if (banda_q == BW'(N_BANDAS - 1)) begin
            estado_d = REPOSO;
          end else begin
            banda_d = banda_q + BW'(1);
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    endcase
  end

  assign perdida = perdida_q;

  // ---- control, delay lines and coefficient bank ----
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= REPOSO;
      banda_q     <= '0;
      idx_q       <= IDX_A1;
      perdida_q   <= 1'b0;
      sal_banda_q <= '0;
      sal_idx_q   <= '0;
      for (int b = 0; b < N_BANDAS; b++) begin
        w1_q[b] <= '0;
        w2_q[b] <= '0;
      end
      // Every band comes out of reset as a unity pass-through.
      for (int i = 0; i < NC; i++) begin
        coef_q[i] <= ((i % 5) == int'(IDX_B0)) ? UNO : '0;
      end
    end else begin
      estado_q    <= estado_d;
      banda_q     <= banda_d;
      idx_q       <= idx_d;
      perdida_q   <= perdida_d;
      sal_banda_q <= sal_banda_d;
      sal_idx_q   <= sal_idx_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      coef_q      <= coef_d;
    end
  end

  // ---- per-sample working registers ----
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    w_q   <= w_d;
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_filtro_biquad_tdm.sv
module tb_filtro_biquad_tdm;

  localparam int     NC   = 20;
  localparam int     FRAC = 14;
  localparam longint YMAX = 64'sd4194303;
  localparam longint YMIN = -64'sd4194304;

  logic               clk = 1'b0;
  logic               reset, en, coef_we, limpia;
  logic signed [22:0] func_ent, coef_dat;
  logic [4:0]         coef_dir;
  logic signed [22:0] sal_banda;
  logic [1:0]         sal_idx;
  logic               sal_valid, busy, perdida;

  int checks   = 0;
  int failures = 0;

  longint coef_m [NC];
  longint w1_m [4];
  longint w2_m [4];
  longint y_exp [4];
  longint last_y;
  int     last_idx;
  bit     perd_m;

  always #5 clk = ~clk;

  filtro_biquad_tdm dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .func_ent  (func_ent),
    .coef_we   (coef_we),
    .coef_dir  (coef_dir),
    .coef_dat  (coef_dat),
    .limpia    (limpia),
    .sal_banda (sal_banda),
    .sal_idx   (sal_idx),
    .sal_valid (sal_valid),
    .busy      (busy),
    .perdida   (perdida)
  );

  // ---------------- reference model ----------------
  function automatic longint sat_m(input longint v);
    if (v > YMAX) return YMAX;
    if (v < YMIN) return YMIN;
    return v;
  endfunction

  function automatic longint mul_m(input longint c, input longint d);
    return (c * d) >>> FRAC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) coef_m[i] = ((i % 5) == 2) ? 64'sd16384 : 64'sd0;
    for (int b = 0; b < 4; b++) begin
      w1_m[b] = 0;
      w2_m[b] = 0;
    end
    last_y   = 0;
    last_idx = 0;
    perd_m   = 1'b0;
  endtask

  task automatic model_sample(input longint x);
    longint w;
    for (int b = 0; b < 4; b++) begin
      w = sat_m(x + mul_m(coef_m[b*5], w1_m[b]) + mul_m(coef_m[b*5+1], w2_m[b]));
      y_exp[b] = sat_m(mul_m(coef_m[b*5+2], w) + mul_m(coef_m[b*5+3], w1_m[b])
                       + mul_m(coef_m[b*5+4], w2_m[b]));
      w2_m[b] = w1_m[b];
      w1_m[b] = w;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b0;
    coef_we = 1'b0;
    limpia  = 1'b0;
    func_ent = '0;
    coef_dir = '0;
    coef_dat = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int dir, input longint val);
    coef_we  = 1'b1;
    coef_dir = 5'(dir);
    coef_dat = 23'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (dir < NC) coef_m[dir] = val;
  endtask

  task automatic pulse_limpia();
    limpia = 1'b1;
    @(negedge clk);
    limpia = 1'b0;
    for (int b = 0; b < 4; b++) begin
      w1_m[b] = 0;
      w2_m[b] = 0;
    end
  endtask

  // Issues one sample and checks cycles T0+1..T0+21. Optional disturbances
  // (0 = none): second strobe, coefficient write, limpia, reset, at cycle k.
  task automatic run_sample(input string name, input longint x, input int en2_at,
                            input int we_at, input int lim_at, input int rst_at);
    bit aborted   = 1'b0;
    bit perd_pend = 1'b0;
    bit exp_busy, exp_valid;
    model_sample(x);
    en       = 1'b1;
    func_ent = 23'(x);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      en      = 1'b0;
      coef_we = 1'b0;
      limpia  = 1'b0;
      if (k == 1) func_ent = 23'($urandom);
      if (reset) begin
        reset   = 1'b0;
        aborted = 1'b1;
        model_reset();
      end
      if (perd_pend) begin
        perd_m    = 1'b1;
        perd_pend = 1'b0;
      end
      exp_busy  = !aborted && (k <= 20);
      exp_valid = !aborted && (k <= 20) && (k % 5 == 0);
      if (exp_valid) begin
        last_y   = y_exp[k/5 - 1];
        last_idx = k/5 - 1;
      end
      checks += 5;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%0b exp=%0b", name, k, busy, exp_busy);
      end
      if (sal_valid !== exp_valid) begin
        failures++;
        $display("FAIL %s sal_valid k=%0d got=%0b exp=%0b", name, k, sal_valid, exp_valid);
      end
      if (perdida !== perd_m) begin
        failures++;
        $display("FAIL %s perdida k=%0d got=%0b exp=%0b", name, k, perdida, perd_m);
      end
      if (sal_banda !== 23'(last_y)) begin
        failures++;
        $display("FAIL %s sal_banda k=%0d got=%0d exp=%0d", name, k, sal_banda, last_y);
      end
      if (sal_idx !== 2'(last_idx)) begin
        failures++;
        $display("FAIL %s sal_idx k=%0d got=%0d exp=%0d", name, k, sal_idx, last_idx);
      end
      if (k == en2_at) begin
        en = 1'b1;
        if (!aborted && k <= 20) perd_pend = 1'b1;
      end
      if (k == we_at) begin
        coef_we  = 1'b1;
        coef_dir = 5'd2;
        coef_dat = '0;
      end
      if (k == lim_at) limpia = 1'b1;
      if (k == rst_at) reset = 1'b1;
    end
    en      = 1'b0;
    coef_we = 1'b0;
    limpia  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%0b exp=0", busy); end
    if (sal_valid !== 1'b0) begin failures++; $display("FAIL reset sal_valid got=%0b exp=0", sal_valid); end
    if (perdida !== 1'b0) begin failures++; $display("FAIL reset perdida got=%0b exp=0", perdida); end
    if (sal_banda !== 23'sd0) begin failures++; $display("FAIL reset sal_banda got=%0d exp=0", sal_banda); end
    if (sal_idx !== 2'd0) begin failures++; $display("FAIL reset sal_idx got=%0d exp=0", sal_idx); end
  endtask

  task automatic test_passthrough();
    do_reset();
    run_sample("passthrough", 5000, 0, 0, 0, 0);
    run_sample("passthrough_neg", -123456, 0, 0, 0, 0);
  endtask

  task automatic test_fir_avg();
    do_reset();
    write_coef(7, 8192);
    write_coef(8, 8192);
    run_sample("fir_avg_0", 16384, 0, 0, 0, 0);
    run_sample("fir_avg_1", 0, 0, 0, 0, 0);
    run_sample("fir_avg_2", 0, 0, 0, 0, 0);
  endtask

  task automatic test_iir_decay();
    do_reset();
    write_coef(0, 8192);
    write_coef(2, 16384);
    run_sample("iir_0", 16384, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) run_sample("iir_n", 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    write_coef(12, 4194303);
    run_sample("sat_pos", 4194303, 0, 0, 0, 0);
    run_sample("sat_neg", -4194303, 0, 0, 0, 0);
  endtask

  task automatic test_overrun();
    do_reset();
    run_sample("overrun", 3000, 7, 3, 0, 0);
    // perdida must stay set and the dropped coefficient write must not show.
    run_sample("overrun_after", -777, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_sample("b2b_last", 1111, 20, 0, 0, 0);
    run_sample("b2b_next", 2222, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_coef(2, 8192);
    run_sample("reset_mid", 4000, 0, 0, 0, 8);
    run_sample("reset_mid_after", 4000, 0, 0, 0, 0);
  endtask

  task automatic test_limpia();
    do_reset();
    write_coef(0, 8192);
    write_coef(5, -4096);
    write_coef(6, 2048);
    run_sample("limpia_a", 16384, 0, 0, 0, 0);
    run_sample("limpia_busy", 1000, 0, 0, 9, 0);
    pulse_limpia();
    run_sample("limpia_b", 16384, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NC; i++)
      write_coef(i, longint'($urandom_range(32768)) - 64'sd16384);
    for (int i = 0; i < 3; i++)
      write_coef(20 + int'($urandom_range(11)), longint'($urandom_range(32768)));
    for (int s = 0; s < 6; s++)
      run_sample("random", longint'($urandom_range(2097152)) - 64'sd1048576, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    coef_we = 1'b0;
    limpia = 1'b0;
    func_ent = '0;
    coef_dir = '0;
    coef_dat = '0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_fir_avg();
    test_iir_decay();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_limpia();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filtro_biquad_tdm.md
FILTRO_BIQUAD_TDM -- requirements
Module: filtro_biquad_tdm

Interface
REQ-001 Parameter ANCHO, default 23, total sample/coefficient width, two's complement.
REQ-002 Parameter MAGNITUD, default 8, integer bits excluding sign.
REQ-003 Parameter FRACCION, default 14, fraction bits (ANCHO = 1 + MAGNITUD + FRACCION).
REQ-004 Parameter N_BANDAS, default 4, number of cascaded-in-parallel biquad bands sharing one multiplier.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  one-cycle sample strobe; func_ent valid when high.
REQ-008 func_ent  in  ANCHO  signed input sample.
REQ-009 coef_we  in  1  coefficient write strobe.
REQ-010 coef_dir  in  clog2(5*N_BANDAS)  coefficient address = banda*5 + idx (idx 0..4 = a1,a2,b0,b1,b2).
REQ-011 coef_dat  in  ANCHO  signed coefficient; a1/a2 stored pre-negated (added, not subtracted).
REQ-012 limpia  in  1  clears delay state of all bands.
REQ-013 sal_banda  out  ANCHO  signed output of band sal_idx.
REQ-014 sal_idx  out  clog2(N_BANDAS)  band index of sal_banda.
REQ-015 sal_valid  out  1  one-cycle strobe, sal_banda/sal_idx valid.
REQ-016 busy  out  1  high while a sample is being processed.
REQ-017 perdida  out  1  sticky overrun flag.

Function
REQ-018 Per band b, per sample: w = x + a1*w1 + a2*w2; y = b0*w + b1*w1 + b2*w2; then w2<=w1, w1<=w.
REQ-019 FSM states REPOSO, CALCULO; REPOSO->CALCULO on en; CALCULO->REPOSO after 5*N_BANDAS cycles.
REQ-020 CALCULO performs exactly one product per cycle, order per band: a1*w1, a2*w2, b0*w, b1*w1, b2*w2; bands in order 0..N_BANDAS-1.
REQ-021 With en high at edge T0, busy is high cycles T0+1..T0+5*N_BANDAS; sal_valid for band b is high exactly in cycle T0+5*(b+1) with sal_idx=b.
REQ-022 func_ent is captured at T0 and held internally; later changes do not affect the sample.
REQ-023 en while busy is ignored and sets perdida; perdida clears only on reset.
REQ-024 en in the last busy cycle is also ignored (no back-to-back acceptance before REPOSO).
REQ-025 Product: full 2*ANCHO-bit signed product, arithmetic-shifted right FRACCION bits (truncation toward minus infinity).
REQ-026 Accumulator ANCHO+3 bits; w and y each saturate to [-2^(ANCHO-1), 2^(ANCHO-1)-1] before storage/output.
REQ-027 coef_we accepted only when busy=0 and en=0; otherwise the write is dropped; coef_dir >= 5*N_BANDAS is dropped.
REQ-028 limpia when busy=0 zeroes all w1/w2 next cycle; limpia while busy is ignored.
REQ-029 sal_banda holds its last value between strobes.

Reset
REQ-030 reset returns FSM to REPOSO; busy, sal_valid, perdida, sal_banda, sal_idx = 0.
REQ-031 reset zeroes all w1/w2 and loads every band with b0 = 2^FRACCION (1.0), a1=a2=b1=b2=0 (pass-through).
REQ-032 reset mid-CALCULO aborts the sample; no sal_valid follows.

Structure
REQ-033 Shared package holds coefficient index constants (IDX_A1..IDX_B2), state encoding, and saturation-limit functions.
REQ-034 One sub-module mult_sat: signed multiply, FRACCION shift, used once (single shared multiplier).

Verification (ANCHO=23, FRACCION=14, N_BANDAS=4)
REQ-035 After reset, en with func_ent=5000 -> sal_valid at T0+5,10,15,20, sal_banda=5000 each, busy low at T0+21.
REQ-036 Band 1 b0=8192, b1=8192 (FIR avg), samples 16384,0 -> band 1 outputs 8192 then 8192, then 0.
REQ-037 Band 0 a1=8192 (0.5), b0=16384, impulse 16384 then zeros -> outputs 16384, 8192, 4096, 2048.
REQ-038 Band 2 b0=4194303 (~256.0), func_ent=4194303 -> sal_banda=4194303 (positive saturation); negated input -> -4194304.
REQ-039 en at T0 and T0+7 -> second ignored, perdida=1 and stays 1; coef_we at T0+3 -> coefficient unchanged.
REQ-040 reset asserted at T0+8 -> no further sal_valid, busy=0, outputs 0; next en yields pass-through outputs.
